// File: rtl/eqy_lockstep_monitor.sv
// eqy_lockstep_monitor
// Lockstep checker for paired gold/gate output streams. Each valid sample is
// compared under a care mask. Mismatching samples are queued as
// {sample index, difference vector} records in a small FIFO that is drained
// through a valid/ready handshake. A sticky status tracks pass/fail/lost.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   clear           : synchronous soft clear of status, counters and FIFO
//   in_valid        : in_gold/in_gate/in_care form a sample this cycle
//   in_gold/in_gate : reference and implementation outputs
//   in_care         : per-bit compare enable (1 = compare)
//   rec_valid/ready : mismatch record handshake (head of FIFO)
//   rec_cycle       : sample index of the head record
//   rec_diff        : masked difference vector of the head record
//   mismatch_seen   : sticky, any mismatch since reset/clear
//   overflow        : sticky, at least one record dropped
//   mismatch_count  : saturating count of mismatching samples
//   state           : 00 CLEAN, 01 FAILED, 10 LOST
module eqy_lockstep_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gold,
  input  logic [WIDTH-1:0] in_gate,
  input  logic [WIDTH-1:0] in_care,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_cycle,
  output logic [WIDTH-1:0] rec_diff,
  output logic             mismatch_seen,
  output logic             overflow,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [1:0]       state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_FAILED = 2'b01,
    ST_LOST   = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] mem_cycle [DEPTH];
  logic [WIDTH-1:0] mem_diff  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;

  logic [WIDTH-1:0] diff_c;
  logic             mism_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [OW-1:0]    occ_next_c;

  // Compare and FIFO control; clear suppresses sample and pop alike.
  always_comb begin
    diff_c     = (in_gold ^ in_gate) & in_care;
    mism_c     = in_valid && (|diff_c) && !clear;
    full_c     = (occ == OW'(DEPTH));
    pop_c      = rec_valid && rec_ready && !clear;
    push_c     = mism_c && (!full_c || pop_c);
    drop_c     = mism_c && full_c && !pop_c;
    occ_next_c = occ + OW'(push_c) - OW'(pop_c);
  end

  // Head record is read straight out of the storage registers.
  assign rec_cycle = mem_cycle[rd_ptr];
  assign rec_diff  = mem_diff[rd_ptr];
  assign state     = state_q;

  // FIFO storage, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_cycle[i] <= '0;
        mem_diff[i]  <= '0;
      end
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      rec_valid      <= 1'b0;
      sample_cnt     <= '0;
      mismatch_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_cycle[i] <= '0;
        mem_diff[i]  <= '0;
      end
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      rec_valid      <= 1'b0;
      sample_cnt     <= '0;
      mismatch_count <= '0;
    end else begin
      if (push_c) begin
        mem_cycle[wr_ptr] <= sample_cnt;
        mem_diff[wr_ptr]  <= diff_c;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ       <= occ_next_c;
      rec_valid <= (occ_next_c != '0);
      // Both counters saturate rather than wrap.
      if (in_valid && (sample_cnt != '1)) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (mism_c && (mismatch_count != '1)) begin
        mismatch_count <= mismatch_count + CNT_W'(1);
      end
    end
  end

  // Status FSM with sticky flags; a drop dominates a first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAN;
      mismatch_seen <= 1'b0;
      overflow      <= 1'b0;
    end else if (clear) begin
      state_q       <= ST_CLEAN;
      mismatch_seen <= 1'b0;
      overflow      <= 1'b0;
    end else if (drop_c) begin
      state_q       <= ST_LOST;
      mismatch_seen <= 1'b1;
      overflow      <= 1'b1;
    end else if (push_c && (state_q == ST_CLEAN)) begin
      state_q       <= ST_FAILED;
      mismatch_seen <= 1'b1;
    end
  end

endmodule
